// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR test datapath.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } align_state_t;

  localparam int unsigned FIR_WIDTH    = 32;
  localparam int unsigned FIR_TAPS_OUT = 44;

endpackage

// File: rtl/fir_gold_align_fifo.sv
// Circular FIFO holding golden samples until the matching FIR output arrives.
// rdata always shows the head entry; pop advances past it.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A push while full is still taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_gold_align.sv
// Aligns golden samples with FIR outputs and presents {filtered, golden}
// pairs to the SSE stage over a valid/ready handshake.
module fir_gold_align
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH     = FIR_WIDTH,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned N_SAMPLES = FIR_TAPS_OUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   gold_valid,
  input  logic [WIDTH-1:0]       gold_in,
  input  logic                   fir_valid,
  input  logic [WIDTH-1:0]       fir_in,
  output logic                   pair_valid,
  input  logic                   pair_ready,
  output logic [WIDTH-1:0]       pair_fir,
  output logic [WIDTH-1:0]       pair_gold,
  output logic                   pair_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic                   err_stall
);

  localparam int unsigned CW = $clog2(N_SAMPLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  align_state_t   state;
  align_state_t   state_nxt;
  logic [CW-1:0]  pair_cnt;
  logic [WIDTH-1:0] fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic           in_run;
  logic           accept;
  logic           blocked;
  logic           fifo_push;
  logic           fifo_pop;
  logic           load;

  // start wins over any same-cycle traffic, so gate everything with it.
  assign in_run    = (state == RUN) & ~start;
  assign accept    = pair_valid & pair_ready;
  assign blocked   = pair_valid & ~pair_ready;
  assign fifo_push = in_run & gold_valid;
  assign fifo_pop  = in_run & fir_valid & ~blocked;
  assign load      = fifo_pop & ~fifo_empty;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (gold_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: start always (re)enters RUN; the accepted last pair ends it.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (accept && pair_last) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Output pair register and saturating pair index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
      pair_fir   <= '0;
      pair_gold  <= '0;
      pair_cnt   <= '0;
    end else if (start) begin
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
      pair_fir   <= '0;
      pair_gold  <= '0;
      pair_cnt   <= '0;
    end else if (load) begin
      pair_valid <= 1'b1;
      pair_fir   <= fir_in;
      pair_gold  <= fifo_rdata;
      pair_last  <= (pair_cnt == LAST_IDX);
      if (pair_cnt != LAST_IDX) pair_cnt <= pair_cnt + 1'b1;
    end else if (accept) begin
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
    end
  end

  // Sticky error flags, only updated while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_stall <= 1'b0;
    end else if (start) begin
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_stall <= 1'b0;
    end else begin
      if (fifo_push & fifo_full & ~load)   err_ovf   <= 1'b1;
      if (in_run & fir_valid & fifo_empty) err_unf   <= 1'b1;
      if (in_run & fir_valid & blocked)    err_stall <= 1'b1;
    end
  end

endmodule
